hough_peak_extractor: RTL
=========================

Name: hough_peak_extractor

Overview:
- Read-side counterpart of the Hough vote accumulator: after voting finishes, it scans the accumulator RAM bin by bin.
- It detects line peaks (votes >= threshold and a local maximum along rho within one theta row).
- Each peak is emitted as a packed {theta, rho, votes} word into the downstream line FIFO, with back-pressure.
- It sits between the accumulator memory and the line-drawing/output stage.

Parameters:
- RHOS, 900: rho bins per theta row.
- THETAS, 180: theta rows.
- VOTE_BITS, 8: width of one accumulator bin.
- THRESHOLD, 100: minimum votes for a peak.
- MAX_LINES, 16: maximum peaks emitted per scan; the scan ends early once reached.
- RHO_BITS, $clog2(RHOS): rho index width.
- THETA_BITS, $clog2(THETAS): theta index width.
- ADDR_BITS, $clog2(RHOS*THETAS): accumulator address width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a scan; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the scan ends.
- acc_rd_en  out  1  accumulator read strobe.
- acc_rd_addr  out  ADDR_BITS  bin address, equal to theta*RHOS+rho.
- acc_rd_data  in  VOTE_BITS  bin value, valid exactly 1 cycle after acc_rd_en.
- out_wr_en  out  1  line FIFO write strobe.
- out_full  in  1  line FIFO full.
- out_din  out  THETA_BITS+RHO_BITS+VOTE_BITS  packed {theta, rho, votes}, theta in the MSBs.
- line_count  out  $clog2(MAX_LINES+1)  peaks emitted in the current or last scan.

Behaviour:
- Reset (reset=0, asynchronous):
  - busy, done, acc_rd_en, out_wr_en = 0; acc_rd_addr, out_din, line_count = 0.
  - State returns to IDLE; the pending queue and window are cleared.
  - A reset during a scan aborts it with no done pulse.
- States: IDLE -> SCAN -> DRAIN -> IDLE.
  - IDLE: on start=1, clear line_count, rho/theta counters and window; go to SCAN.
  - SCAN:
    - Issue reads in address order 0..RHOS*THETAS-1.
    - rho and theta are held as counters; rho wraps at RHOS-1 and theta increments. No multiplier.
    - After the final address is issued, go to DRAIN.
  - DRAIN: wait for the last read data and for the pending queue to empty; then pulse done for 1 cycle and return to IDLE.
- Window:
  - Each valid datum (acc_rd_en delayed 1 cycle) shifts a 3-entry window {prev, cur, next} for the current theta row.
  - Bins outside the row read as 0 (prev at rho=0, next at rho=RHOS-1).
  - When rho r arrives, evaluate bin r-1 (if r>0). When r=RHOS-1 arrives, also evaluate bin r in the same cycle.
- Peak rule: v >= THRESHOLD && v > left && v >= right, so on a plateau the left bin wins.
  - Adjacent bins in one row can never both qualify, so at most 1 candidate is produced per datum.
- Pending queue:
  - 2-entry FIFO, preserving candidate order.
  - The head is written when out_full=0: out_wr_en=1 with out_din equal to the head, for one cycle per word.
  - acc_rd_en=0 whenever (queue count >= 1 && out_full=1) or count == 2. The one read already in flight may still add one entry, so the queue never overflows.
  - When out_full deasserts, reads resume at the held address with no skipped or duplicated bins.
- line_count:
  - Increments on each out_wr_en.
  - On reaching MAX_LINES, further candidates are discarded, reads stop, and the block enters DRAIN immediately.
  - It holds its value until the next start.
- Simultaneous events:
  - start in the same cycle as done is ignored.
  - out_full changing in the same cycle as a candidate arrives is handled by the queue.
- Latency: with out_full=0 throughout, done is asserted within RHOS*THETAS+4 cycles of start.

Test Plan:
- Bench parameters RHOS=16, THETAS=4, THRESHOLD=100 unless noted.
- All bins 0, start pulse -> no out_wr_en; done within 68 cycles; line_count=0; busy falls with done.
- Bins theta=2 rho=7 votes=150, rho 6 and 8 = 120 -> exactly one write, out_din={2,7,150}; line_count=1.
- Plateau theta=1 rho 10 and 11 both = 130 -> one write {1,10,130}; rho 11 is not emitted.
- Row boundary theta=0 rho=15 = 200 and theta=1 rho=0 = 200 -> two writes in order {0,15,200} then {1,0,200}.
- Three peaks with out_full held high for 40 cycles from the first candidate -> acc_rd_en stays low while the queue holds 2; all 3 words arrive in address order after release; no bin skipped.
- 20 separated peaks with MAX_LINES=16 -> 16 writes, then early done; reset pulled low mid-scan on a second run -> all outputs 0, no done, and a new start rescans from address 0.

Source files
------------

// File: rtl/hough_peak_extractor.sv
// Scans a Hough accumulator row by row and queues local-maximum bins along rho
// as packed {theta, rho, votes} words for the downstream line FIFO.
module hough_peak_extractor #(
    parameter int RHOS       = 900,
    parameter int THETAS     = 180,
    parameter int VOTE_BITS  = 8,
    parameter int THRESHOLD  = 100,
    parameter int MAX_LINES  = 16,
    parameter int RHO_BITS   = $clog2(RHOS),
    parameter int THETA_BITS = $clog2(THETAS),
    parameter int ADDR_BITS  = $clog2(RHOS*THETAS)
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    acc_rd_en,
    output logic [ADDR_BITS-1:0]                    acc_rd_addr,
    input  logic [VOTE_BITS-1:0]                    acc_rd_data,
    output logic                                    out_wr_en,
    input  logic                                    out_full,
    output logic [THETA_BITS+RHO_BITS+VOTE_BITS-1:0] out_din,
    output logic [$clog2(MAX_LINES+1)-1:0]          line_count,
    output logic [1:0]                              dbg_state
);

    localparam int W       = THETA_BITS + RHO_BITS + VOTE_BITS;
    localparam int LC_BITS = $clog2(MAX_LINES + 1);

    localparam logic [RHO_BITS-1:0]   RHO_LAST   = RHO_BITS'(RHOS - 1);
    localparam logic [THETA_BITS-1:0] THETA_LAST = THETA_BITS'(THETAS - 1);
    localparam logic [VOTE_BITS-1:0]  TH_V       = VOTE_BITS'(THRESHOLD);
    localparam logic [LC_BITS-1:0]    LC_MAX     = LC_BITS'(MAX_LINES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   done_nxt;

    logic [RHO_BITS-1:0]   rho_cnt;
    logic [THETA_BITS-1:0] theta_cnt;

    logic                  rd_valid;
    logic [RHO_BITS-1:0]   d_rho;
    logic [THETA_BITS-1:0] d_theta;

    logic [VOTE_BITS-1:0]  prev_v;
    logic [VOTE_BITS-1:0]  cur_v;

    logic                  cand_valid;
    logic [W-1:0]          cand_word;
    logic                  push;

    logic [W-1:0]          q0;
    logic [W-1:0]          q1;
    logic [1:0]            q_cnt;

    logic                  start_ok;
    logic                  lc_max;
    logic                  stall;
    logic                  last_addr;
    logic                  drain_done;

    // Handshakes: a read is issued in every cycle acc_rd_en=1 and its data is
    // taken exactly one cycle later; a FIFO word transfers in every cycle
    // out_wr_en=1, which is only raised while out_full=0.
    always_comb begin
        start_ok   = (state == S_IDLE) && start && !done;
        lc_max     = (line_count == LC_MAX);
        stall      = ((q_cnt != 2'd0) && out_full) || (q_cnt == 2'd2);
        acc_rd_en  = (state == S_SCAN) && !stall && !lc_max;
        last_addr  = (rho_cnt == RHO_LAST) && (theta_cnt == THETA_LAST);
        out_wr_en  = (q_cnt != 2'd0) && !out_full && !lc_max;
        out_din    = q0;
        drain_done = (state == S_DRAIN) && !rd_valid && (q_cnt == 2'd0);
        dbg_state  = state;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_SCAN;
            end
            S_SCAN: begin
                if (lc_max || (acc_rd_en && last_addr)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // busy drops on the same edge that raises done
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            done  <= done_nxt;
        end
    end

    // Address, rho and theta advance together so no multiply is needed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rho_cnt     <= '0;
            theta_cnt   <= '0;
            acc_rd_addr <= '0;
        end else if (start_ok) begin
            rho_cnt     <= '0;
            theta_cnt   <= '0;
            acc_rd_addr <= '0;
        end else if (acc_rd_en) begin
            acc_rd_addr <= acc_rd_addr + ADDR_BITS'(1);
            if (rho_cnt == RHO_LAST) begin
                rho_cnt   <= '0;
                theta_cnt <= theta_cnt + THETA_BITS'(1);
            end else begin
                rho_cnt <= rho_cnt + RHO_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            d_rho    <= '0;
            d_theta  <= '0;
        end else begin
            rd_valid <= acc_rd_en;
            if (acc_rd_en) begin
                d_rho   <= rho_cnt;
                d_theta <= theta_cnt;
            end
        end
    end

    // prev is zeroed at the start of each row so bin 0 sees an empty left neighbour
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_v <= '0;
            cur_v  <= '0;
        end else if (start_ok) begin
            prev_v <= '0;
            cur_v  <= '0;
        end else if (rd_valid) begin
            prev_v <= (d_rho == '0) ? '0 : cur_v;
            cur_v  <= acc_rd_data;
        end
    end

    // Bin rho-1 is judged when rho arrives; the last bin of a row is judged
    // against an implicit zero on its right. The two cases are exclusive.
    always_comb begin
        cand_valid = 1'b0;
        cand_word  = '0;
        if (rd_valid && (d_rho != '0) && (cur_v >= TH_V) &&
            (cur_v > prev_v) && (cur_v >= acc_rd_data)) begin
            cand_valid = 1'b1;
            cand_word  = {d_theta, d_rho - RHO_BITS'(1), cur_v};
        end else if (rd_valid && (d_rho == RHO_LAST) &&
                     (acc_rd_data >= TH_V) && (acc_rd_data > cur_v)) begin
            cand_valid = 1'b1;
            cand_word  = {d_theta, d_rho, acc_rd_data};
        end
        push = cand_valid && !lc_max;
    end

    // Two-entry pending queue; q0 is the head presented on out_din.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q0    <= '0;
            q1    <= '0;
            q_cnt <= 2'd0;
        end else if (start_ok || lc_max) begin
            q_cnt <= 2'd0;
        end else begin
            case ({push, out_wr_en})
                2'b10: begin
                    if (q_cnt == 2'd0) q0 <= cand_word;
                    else               q1 <= cand_word;
                    q_cnt <= q_cnt + 2'd1;
                end
                2'b01: begin
                    q0    <= q1;
                    q_cnt <= q_cnt - 2'd1;
                end
                2'b11: begin
                    if (q_cnt == 2'd1) begin
                        q0 <= cand_word;
                    end else begin
                        q0 <= q1;
                        q1 <= cand_word;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            line_count <= '0;
        end else if (start_ok) begin
            line_count <= '0;
        end else if (out_wr_en) begin
            line_count <= line_count + LC_BITS'(1);
        end
    end

endmodule
